// File: rtl/pwm_axil_regs.sv
`timescale 1ns/1ps
// AXI4-Lite responder with a four-word register map (CTRL/PERIOD/DUTY/COUNT)
// and a PWM core whose period and duty are reloaded only at counter wrap.
module pwm_axil_regs #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
   parameter int unsigned C_CNT_WIDTH        = 16
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic                              pwm_out,
   output logic                              period_tick
);

   localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
   localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned CW = C_CNT_WIDTH;

   localparam logic [1:0] IDX_CTRL    = 2'd0;
   localparam logic [1:0] IDX_PERIOD  = 2'd1;
   localparam logic [1:0] IDX_DUTY    = 2'd2;
   localparam logic [1:0] IDX_COUNT   = 2'd3;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                          r_ready_en;
   logic                          r_aw_full;
   logic [C_S_AXI_ADDR_WIDTH-1:0] r_awaddr;
   logic                          r_w_full;
   logic [DW-1:0]                 r_wdata;
   logic [SW-1:0]                 r_wstrb;
   logic                          r_bvalid;
   logic [1:0]                    r_bresp;
   logic                          r_rvalid;
   logic [DW-1:0]                 r_rdata;

   logic [1:0]                    r_ctrl;
   logic [CW-1:0]                 r_period;
   logic [CW-1:0]                 r_duty;
   logic [CW-1:0]                 r_cnt;
   logic [CW-1:0]                 r_per_act;
   logic [CW-1:0]                 r_duty_act;
   logic                          r_pwm;
   logic                          r_tick;

   logic          w_aw_hs;
   logic          w_w_hs;
   logic          w_ar_hs;
   logic          w_wr_fire;
   logic [1:0]    w_wr_idx;
   logic [1:0]    w_rd_idx;
   logic [DW-1:0] w_rd_word;
   logic [DW-1:0] w_wr_old;
   logic [DW-1:0] w_wr_new;
   logic          w_wrap;
   logic          w_unused;

   function automatic logic [DW-1:0] reg_word(input logic [1:0]    idx,
                                              input logic [1:0]    ctrl,
                                              input logic [CW-1:0] period,
                                              input logic [CW-1:0] duty,
                                              input logic [CW-1:0] cnt);
      logic [DW-1:0] word;
      case (idx)
         IDX_CTRL:   word = DW'(ctrl);
         IDX_PERIOD: word = DW'(period);
         IDX_DUTY:   word = DW'(duty);
         default:    word = DW'(cnt);
      endcase
      return word;
   endfunction

   assign S_AXI_AWREADY = r_ready_en & ~r_aw_full & ~r_bvalid;
   assign S_AXI_WREADY  = r_ready_en & ~r_w_full  & ~r_bvalid;
   assign S_AXI_ARREADY = r_ready_en & ~r_rvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = RESP_OKAY;
   assign S_AXI_RVALID  = r_rvalid;
   assign pwm_out       = r_pwm;
   assign period_tick   = r_tick;

   assign w_aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_w_hs    = S_AXI_WVALID  & S_AXI_WREADY;
   assign w_ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
   assign w_wr_fire = r_aw_full & r_w_full & ~r_bvalid;
   assign w_wr_idx  = r_awaddr[3:2];
   assign w_rd_idx  = S_AXI_ARADDR[3:2];
   assign w_wrap    = (r_cnt == r_per_act);

   assign w_rd_word = reg_word(w_rd_idx, r_ctrl, r_period, r_duty, r_cnt);
   assign w_wr_old  = reg_word(w_wr_idx, r_ctrl, r_period, r_duty, r_cnt);

   // Byte-lane merge of the latched write data onto the current register word
   always_comb begin
      w_wr_new = w_wr_old;
      for (int unsigned b = 0; b < SW; b++) begin
         if (r_wstrb[b]) w_wr_new[8*b +: 8] = r_wdata[8*b +: 8];
      end
   end

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0],
                       r_awaddr[1:0], w_wr_new};

   // Bus side: independent AW/W capture, single outstanding write, read response
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_ready_en <= 1'b0;
         r_aw_full  <= 1'b0;
         r_awaddr   <= '0;
         r_w_full   <= 1'b0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
         r_ctrl     <= '0;
         r_period   <= '0;
         r_duty     <= '0;
      end else begin
         r_ready_en <= 1'b1;
         if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_awaddr  <= S_AXI_AWADDR;
         end
         if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_wdata  <= S_AXI_WDATA;
            r_wstrb  <= S_AXI_WSTRB;
         end
         if (w_wr_fire) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= (w_wr_idx == IDX_COUNT) ? RESP_SLVERR : RESP_OKAY;
            case (w_wr_idx)
               IDX_CTRL:   r_ctrl   <= w_wr_new[1:0];
               IDX_PERIOD: r_period <= w_wr_new[CW-1:0];
               IDX_DUTY:   r_duty   <= w_wr_new[CW-1:0];
               default:    ;
            endcase
         end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
         end
         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_word;
         end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   // PWM core: shadows track PERIOD/DUTY while disabled, reload at wrap when enabled
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_cnt      <= '0;
         r_per_act  <= '0;
         r_duty_act <= '0;
         r_pwm      <= 1'b0;
         r_tick     <= 1'b0;
      end else if (!r_ctrl[0]) begin
         r_cnt      <= '0;
         r_per_act  <= r_period;
         r_duty_act <= r_duty;
         r_pwm      <= r_ctrl[1];
         r_tick     <= 1'b0;
      end else begin
         r_pwm  <= (r_cnt < r_duty_act) ^ r_ctrl[1];
         r_tick <= w_wrap;
         if (w_wrap) begin
            r_cnt      <= '0;
            r_per_act  <= r_period;
            r_duty_act <= r_duty;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_pwm_axil_regs.sv
`timescale 1ns/1ps
// Scoreboard bench for pwm_axil_regs: bus responses and PWM period statistics
// are checked against a register/waveform model kept in the bench.
module tb_pwm_axil_regs;

   logic        ACLK;
   logic        ARESET;
   logic [3:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [3:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic        pwm_out;
   logic        period_tick;

   pwm_axil_regs #(
      .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .C_CNT_WIDTH(16)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .pwm_out(pwm_out), .period_tick(period_tick)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic [1:0]  resp;
      string       name;
   } exp_t;

   exp_t bq[$];
   exp_t rq[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Register model: CTRL, PERIOD, DUTY (COUNT is live, not stored)
   logic [31:0] m_reg [3];
   logic [31:0] m_mask [3];

   // PWM expectation per full period window
   bit pwm_chk = 0;
   bit win_ok  = 0;
   int win_len = 0;
   int win_high = 0;
   int exp_len = 0;
   int exp_high = 0;
   int tick_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out", name);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s, input logic [31:0] mask);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r & mask;
   endfunction

   // Monitor: pops scoreboard entries on each B/R handshake, measures PWM windows
   exp_t e;
   always @(negedge ACLK) begin
      if (ARESET) begin
         win_ok   = 0;
         win_len  = 0;
         win_high = 0;
      end else begin
         if (S_AXI_BVALID && S_AXI_BREADY) begin
            if (bq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_b: got BRESP %0d required no response", S_AXI_BRESP);
            end else begin
               e = bq.pop_front();
               check({e.name, "_bresp"}, 32'(S_AXI_BRESP), 32'(e.resp));
            end
         end
         if (S_AXI_RVALID && S_AXI_RREADY) begin
            if (rq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_r: got RDATA 0x%0h required no response", S_AXI_RDATA);
            end else begin
               e = rq.pop_front();
               n_cmp++;
               if (S_AXI_RDATA < e.lo || S_AXI_RDATA > e.hi || S_AXI_RRESP !== e.resp) begin
                  n_bad++;
                  $display("FAIL %s_rdata: got 0x%0h resp %0d required 0x%0h..0x%0h resp %0d",
                           e.name, S_AXI_RDATA, S_AXI_RRESP, e.lo, e.hi, e.resp);
               end
            end
         end
         if (period_tick) begin
            if (pwm_chk && win_ok) begin
               check("pwm_period_len", 32'(win_len), 32'(exp_len));
               check("pwm_active_cycles", 32'(win_high), 32'(exp_high));
            end
            win_ok   = pwm_chk;
            win_len  = 0;
            win_high = 0;
            tick_cnt++;
         end
         win_len++;
         if (pwm_out) win_high++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge ACLK); #1; end
   endtask

   task automatic wait_empty(input string name);
      for (int c = 0; c < 50; c++) begin
         if (bq.size() == 0 && rq.size() == 0) return;
         cyc(1);
      end
      fail_now({name, "_response"});
      bq.delete();
      rq.delete();
   endtask

   task automatic wait_ticks(input int n);
      int start;
      start = tick_cnt;
      for (int c = 0; c < 1000; c++) begin
         if (tick_cnt - start >= n) return;
         cyc(1);
      end
      fail_now("period_tick_wait");
   endtask

   task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                              input string name);
      exp_t x;
      x.lo = 0; x.hi = 0; x.name = name;
      x.resp = (a[3:2] == 2'd3) ? 2'b10 : 2'b00;
      bq.push_back(x);
      if (a[3:2] != 2'd3) m_reg[a[3:2]] = merge(m_reg[a[3:2]], d, s, m_mask[a[3:2]]);
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input string name);
      bit aw_hs, w_hs;
      model_write(a, d, s, name);
      S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
      for (int c = 0; c < 20 && (S_AXI_AWVALID || S_AXI_WVALID); c++) begin
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         cyc(1);
         if (aw_hs) S_AXI_AWVALID = 1'b0;
         if (w_hs)  S_AXI_WVALID  = 1'b0;
      end
      if (S_AXI_AWVALID || S_AXI_WVALID) begin
         fail_now({name, "_handshake"});
         S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      end
      wait_empty(name);
   endtask

   task automatic axi_read(input logic [3:0] a, input logic [31:0] lo, input logic [31:0] hi,
                           input string name);
      exp_t x;
      bit hs;
      x.lo = lo; x.hi = hi; x.resp = 2'b00; x.name = name;
      rq.push_back(x);
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
      for (int c = 0; c < 20 && S_AXI_ARVALID; c++) begin
         hs = S_AXI_ARREADY;
         cyc(1);
         if (hs) S_AXI_ARVALID = 1'b0;
      end
      if (S_AXI_ARVALID) begin
         fail_now({name, "_ar_handshake"});
         S_AXI_ARVALID = 1'b0;
      end
      wait_empty(name);
   endtask

   task automatic read_model(input logic [3:0] a, input string name);
      logic [31:0] v;
      v = (a[3:2] == 2'd3) ? 32'h0 : m_reg[a[3:2]];
      axi_read(a, v, v, name);
   endtask

   // W leads AW by w_lead cycles (negative: AW leads); BREADY held low 5 cycles
   task automatic wr_ordered(input logic [3:0] a, input logic [31:0] d, input int w_lead,
                             input string name);
      int t_w, t_aw, last;
      model_write(a, d, 4'hF, name);
      t_w  = (w_lead >= 0) ? 0 : -w_lead;
      t_aw = (w_lead >= 0) ? w_lead : 0;
      last = (t_w > t_aw) ? t_w : t_aw;
      S_AXI_BREADY = 1'b0;
      for (int c = 0; c <= last; c++) begin
         if (c == t_w) begin
            S_AXI_WDATA = d; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
            check({name, "_wready"}, 32'(S_AXI_WREADY), 32'd1);
         end
         if (c == t_aw) begin
            S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
            check({name, "_awready"}, 32'(S_AXI_AWREADY), 32'd1);
         end
         cyc(1);
         S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
         check({name, "_bvalid_low"}, 32'(S_AXI_BVALID), 32'd0);
      end
      cyc(1);
      check({name, "_bvalid_rise"}, 32'(S_AXI_BVALID), 32'd1);
      for (int c = 0; c < 5; c++) begin
         cyc(1);
         check({name, "_bvalid_hold"}, 32'(S_AXI_BVALID), 32'd1);
         check({name, "_awready_blocked"}, 32'(S_AXI_AWREADY), 32'd0);
      end
      S_AXI_BREADY = 1'b1;
      wait_empty(name);
      check({name, "_single_b"}, 32'(S_AXI_BVALID), 32'd0);
   endtask

   task automatic set_pwm(input int per, input int duty, input bit inv, input string name);
      int act;
      pwm_chk = 0;
      axi_write(4'h4, 32'(per), 4'hF, {name, "_period"});
      axi_write(4'h8, 32'(duty), 4'hF, {name, "_duty"});
      axi_write(4'h0, {30'd0, inv, 1'b1}, 4'hF, {name, "_ctrl"});
      exp_len  = per + 1;
      act      = (duty < per + 1) ? duty : per + 1;
      exp_high = inv ? exp_len - act : act;
      wait_ticks(2);
      pwm_chk = 1;
      wait_ticks(3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      m_mask[0] = 32'h3; m_mask[1] = 32'hFFFF; m_mask[2] = 32'hFFFF;
      for (int i = 0; i < 3; i++) m_reg[i] = 32'h0;
      ARESET = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b1;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY = 1'b1;
      cyc(3);
      check("rst_awready", 32'(S_AXI_AWREADY), 0);
      check("rst_wready", 32'(S_AXI_WREADY), 0);
      check("rst_arready", 32'(S_AXI_ARREADY), 0);
      check("rst_bvalid", 32'(S_AXI_BVALID), 0);
      check("rst_rvalid", 32'(S_AXI_RVALID), 0);
      check("rst_rdata", S_AXI_RDATA, 0);
      check("rst_pwm", 32'(pwm_out), 0);
      check("rst_tick", 32'(period_tick), 0);
      ARESET = 1'b0;
      cyc(1);
      check("post_rst_awready", 32'(S_AXI_AWREADY), 1);
      check("post_rst_wready", 32'(S_AXI_WREADY), 1);
      check("post_rst_arready", 32'(S_AXI_ARREADY), 1);

      // Register readback, COUNT write rejected
      axi_write(4'h0, 32'h1, 4'hF, "wr_ctrl");
      axi_write(4'h4, 32'h2, 4'hF, "wr_period");
      axi_write(4'h8, 32'h3, 4'hF, "wr_duty");
      axi_write(4'hC, 32'h4, 4'hF, "wr_count");
      read_model(4'h0, "rd_ctrl");
      read_model(4'h4, "rd_period");
      read_model(4'h8, "rd_duty");
      axi_read(4'hC, 32'h0, 32'h2, "rd_count_run");
      axi_write(4'h0, 32'h0, 4'hF, "wr_ctrl_off");

      // Byte strobes
      axi_write(4'h4, 32'h0000_1234, 4'b1111, "strb_full");
      axi_write(4'h4, 32'hFFFF_FFFF, 4'b0001, "strb_byte0");
      axi_read(4'h4, 32'h0000_12FF, 32'h0000_12FF, "strb_readback");

      // Channel ordering
      wr_ordered(4'h8, 32'h0000_0011, 3, "order_w_first");
      read_model(4'h8, "order_rd1");
      wr_ordered(4'h8, 32'h0000_0022, -2, "order_aw_first");
      read_model(4'h8, "order_rd2");
      wr_ordered(4'h8, 32'h0000_0033, 0, "order_same");
      read_model(4'h8, "order_rd3");

      // Randomized register traffic with the PWM disabled
      for (int i = 0; i < 40; i++) begin
         logic [3:0] a;
         if ($urandom_range(0, 1) == 0) begin
            a = {2'(32'($urandom_range(1, 3))), 2'(32'($urandom_range(0, 3)))};
            axi_write(a, $urandom, 4'($urandom_range(0, 15)), "rnd_wr");
         end else begin
            a = {2'(32'($urandom_range(0, 3))), 2'(32'($urandom_range(0, 3)))};
            read_model(a, "rnd_rd");
         end
      end

      // PWM waveform, inversion, buffered update, boundaries
      set_pwm(9, 3, 1'b0, "pwm_basic");
      set_pwm(9, 3, 1'b1, "pwm_inv");
      set_pwm(9, 3, 1'b0, "pwm_restore");
      wait_ticks(1);
      cyc(2);
      axi_write(4'h8, 32'd7, 4'hF, "buf_duty7");
      wait_ticks(1);
      exp_high = 7;
      wait_ticks(2);
      set_pwm(9, 0, 1'b0, "pwm_duty0");
      set_pwm(9, 20, 1'b0, "pwm_duty20");
      set_pwm(0, 20, 1'b0, "pwm_period0");

      // Disabled with INV: output parks at the inverted level, counter idle
      pwm_chk = 0;
      axi_write(4'h0, 32'h2, 4'hF, "ctrl_inv_off");
      cyc(3);
      check("off_pwm_inv", 32'(pwm_out), 1);
      check("off_tick", 32'(period_tick), 0);
      read_model(4'hC, "off_count");

      // Async reset with a read response pending and the output active
      set_pwm(9, 20, 1'b0, "pre_reset");
      pwm_chk = 0;
      S_AXI_RREADY = 1'b0;
      S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
      cyc(1);
      S_AXI_ARVALID = 1'b0;
      check("pre_reset_rvalid", 32'(S_AXI_RVALID), 1);
      check("pre_reset_pwm", 32'(pwm_out), 1);
      #2;
      ARESET = 1'b1;
      for (int i = 0; i < 3; i++) m_reg[i] = 32'h0;
      #1;
      check("arst_rvalid", 32'(S_AXI_RVALID), 0);
      check("arst_rdata", S_AXI_RDATA, 0);
      check("arst_bvalid", 32'(S_AXI_BVALID), 0);
      check("arst_bresp", 32'(S_AXI_BRESP), 0);
      check("arst_rresp", 32'(S_AXI_RRESP), 0);
      check("arst_pwm", 32'(pwm_out), 0);
      check("arst_tick", 32'(period_tick), 0);
      check("arst_awready", 32'(S_AXI_AWREADY), 0);
      check("arst_arready", 32'(S_AXI_ARREADY), 0);
      cyc(1);
      ARESET = 1'b0;
      S_AXI_RREADY = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         check("post_arst_no_r", 32'(S_AXI_RVALID), 0);
         check("post_arst_no_b", 32'(S_AXI_BVALID), 0);
      end
      read_model(4'h0, "post_arst_ctrl");
      read_model(4'h4, "post_arst_period");

      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pwm_axil_regs.md
# pwm_axil_regs

AXI4-Lite responder and PWM core for the PWM generator IP. It answers the bus master's single-beat register writes and reads. It holds a four-word register map and drives a period-buffered PWM output plus a per-period tick. It sits between the AXI interconnect (S00_AXI) and the IP's external PWM pin.

## Interface
**Parameters**
- C_S_AXI_DATA_WIDTH, 32: bus data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; the map uses 0x0 to 0xC.
- C_CNT_WIDTH, 16: PWM counter width, 1 to 32.

**Ports** (clock and reset first)
- ACLK, in, 1: the single clock for the block.
- ARESET, in, 1: asynchronous, active-high reset.
- S_AXI_AWADDR, in, 4; S_AXI_AWPROT, in, 3 (ignored); S_AXI_AWVALID, in, 1; S_AXI_AWREADY, out, 1.
- S_AXI_WDATA, in, 32; S_AXI_WSTRB, in, 4; S_AXI_WVALID, in, 1; S_AXI_WREADY, out, 1.
- S_AXI_BRESP, out, 2; S_AXI_BVALID, out, 1; S_AXI_BREADY, in, 1.
- S_AXI_ARADDR, in, 4; S_AXI_ARPROT, in, 3 (ignored); S_AXI_ARVALID, in, 1; S_AXI_ARREADY, out, 1.
- S_AXI_RDATA, out, 32; S_AXI_RRESP, out, 2; S_AXI_RVALID, out, 1; S_AXI_RREADY, in, 1.
- pwm_out, out, 1: PWM waveform.
- period_tick, out, 1: one-cycle pulse at each counter wrap.

## Operation
**Register map.** Decode uses address bits [3:2]; bits [1:0] are ignored.
- 0x0 CTRL, RW: bit0 EN, bit1 INV. Other bits read 0.
- 0x4 PERIOD, RW: bits [C_CNT_WIDTH-1:0]. A PWM period lasts PERIOD+1 cycles.
- 0x8 DUTY, RW: bits [C_CNT_WIDTH-1:0]. The output is active while cnt < duty_act.
- 0xC COUNT, RO: the live counter value. A write here changes nothing and returns BRESP=SLVERR (2'b10).
- All other accesses return OKAY (2'b00). WSTRB is honoured per byte. Unimplemented bits are not stored and read 0.

**Write channel.**
- AW and W are captured independently, in either order or in the same cycle.
- AWREADY is high while no address is latched and BVALID is low. WREADY follows the same rule for data.
- Once both are latched, the register update occurs, and BVALID rises on the next cycle.
- BVALID holds until BREADY. Only one write is outstanding at a time.

**Read channel.**
- ARREADY is high while RVALID is low.
- After an AR handshake, RDATA and RRESP are registered, and RVALID rises on the next cycle.
- RVALID holds, with data stable, until RREADY.
- A read and a write in the same cycle are both serviced. A read of a register written in the same cycle returns the old value.

**PWM core.**
- The shadow registers per_act and duty_act load from PERIOD and DUTY:
  - every cycle while EN=0;
  - at a wrap, when cnt == per_act, while EN=1.
- With EN=0: cnt is held at 0, pwm_out = INV, and period_tick = 0.
- With EN=1: cnt increments each cycle and wraps from per_act to 0. period_tick is 1 in the cycle after cnt == per_act.
- pwm_out is the registered value of (cnt < duty_act) XOR INV. It lags cnt by one cycle.
- Boundaries:
  - DUTY=0 gives a constant inactive level.
  - DUTY > per_act gives a constant active level.
  - PERIOD=0 makes cnt stay at 0, with period_tick high every cycle.
- A PERIOD or DUTY write during a period takes effect only at the next wrap. There is no glitch mid-period.

## Timing
- **Reset values:**
  - AWREADY=WREADY=ARREADY=0 while ARESET is asserted. They go to 1 on the first cycle after deassertion.
  - BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0.
  - CTRL=PERIOD=DUTY=0, cnt=0, per_act=duty_act=0.
  - pwm_out=0, period_tick=0.
- **Latency:**
  - Write: AW+W both latched to BVALID is 1 cycle. The register value is visible on a read issued in the BVALID cycle.
  - Read: AR handshake to RVALID is 1 cycle.
  - Minimum throughput: one write per 3 cycles and one read per 2 cycles when BREADY and RREADY are held at 1.
- **Reset mid-transaction:** a pending AW, W, B or R is dropped. No response is issued after reset.
- **Simultaneous EN write and wrap:** the write takes effect on the cycle after the B update. Clearing EN forces cnt=0 on the next cycle.

## Test plan
- **Register readback:** write 1, 2, 3 to 0x0, 0x4, 0x8, then 4 to 0xC; read all four. Required: BRESP OKAY ×3 then SLVERR. Reads return 0x1, 0x2, 0x3, and a COUNT value in 0 to 2.
- **Byte strobes:** write PERIOD=0x0000_1234 with WSTRB=4'b1111, then 0xFFFF_FFFF with WSTRB=4'b0001. Required: readback 0x0000_12FF.
- **Channel ordering:** present W 3 cycles before AW, then AW alone, then both in the same cycle. Each case gives exactly one BVALID, one cycle after the later handshake. Hold BREADY=0 for 5 cycles: BVALID stays 1 and AWREADY stays 0.
- **PWM waveform:** set PERIOD=9, DUTY=3, then EN=1. Required: pwm_out is high 3 cycles and low 7, repeating every 10 cycles, with period_tick every 10 cycles. Then set INV=1: the waveform is inverted.
- **Buffered update and boundaries:**
  - Write DUTY=7 mid-period: no change until the next period_tick.
  - DUTY=0 gives pwm_out constant 0.
  - DUTY=20 gives constant 1.
  - PERIOD=0 gives period_tick high every cycle.
- **Async reset:** assert ARESET for 1 cycle while RVALID=1 and pwm_out=1. Required: every output is at its reset value immediately, with no response after release.
